// File: rtl/floo_tgen_pkg.sv
// Shared definitions for the HBM traffic generator.
//   - tgen_state_e : generator FSM states
//   - err_cnt_t    : 16-bit saturating error counter type
//   - WdogLimit    : watchdog expiry value (used with FLOO_TGEN_TIMEOUT_EN)
//   - tgen_pattern : 32-bit lane pattern for (seed, txn, beat, lane)
//   - axi_req_t / axi_rsp_t : default AXI structs (48b addr, 512b data,
//     3b id, 1b user)
package floo_tgen_pkg;

  localparam int unsigned AxiAddrWidth = 48;
  localparam int unsigned AxiDataWidth = 512;
  localparam int unsigned AxiIdWidth   = 3;
  localparam int unsigned AxiUserWidth = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW,
    ST_WR_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_DONE
  } tgen_state_e;

  typedef logic [15:0] err_cnt_t;

  localparam logic [15:0] WdogLimit = 16'hFFFF;
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  BurstIncr = 2'b01;

  function automatic logic [31:0] tgen_pattern(input logic [31:0] seed,
                                               input logic [15:0] txn,
                                               input logic [7:0]  beat,
                                               input logic [7:0]  lane);
    return seed ^ {txn, beat, lane};
  endfunction

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [5:0]              atop;
    logic [AxiUserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
    logic [AxiUserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [1:0]              resp;
    logic [AxiUserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AxiUserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [AxiUserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    axi_b_chan_t  b;
    logic         r_valid;
    axi_r_chan_t  r;
  } axi_rsp_t;

endpackage

// File: rtl/floo_tgen_pattern_gen.sv
// Registered beat counter with last-beat flag and pattern data output.
// One instance follows the W channel, another the R channel.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : hold the counter at beat 0 (channel not active)
//   advance_i     : a beat handshake completed this cycle
//   seed_i, txn_i : pattern seed and current transaction index
//   last_o        : current beat is beat BurstLen-1
//   data_o        : expected/driven data for the current beat
module floo_tgen_pattern_gen
  import floo_tgen_pkg::*;
#(
  parameter int unsigned DataWidth = 512,
  parameter int unsigned BurstLen  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  logic [31:0]          seed_i,
  input  logic [15:0]          txn_i,
  output logic                 last_o,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned NumLanes = DataWidth / 32;
  localparam logic [7:0]  LastBeat = 8'(BurstLen - 1);

  logic [7:0] beat_q, beat_d;

  assign last_o = (beat_q == LastBeat);

  // Wrapping after the last beat keeps the counter sane even if the
  // subordinate never signals r_last.
  always_comb begin
    beat_d = beat_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (advance_i) begin
      beat_d = last_o ? 8'd0 : beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  always_comb begin
    data_o = '0;
    for (int l = 0; l < NumLanes; l++) begin
      data_o[l*32 +: 32] = tgen_pattern(seed_i, txn_i, beat_q, 8'(l));
    end
  end

endmodule

// File: rtl/floo_hbm_traffic_gen.sv
// AXI manager traffic generator/checker for the HBM test node.
// On start: writes NumTxns bursts of BurstLen beats with a seeded pattern,
// reading each burst back right after its B response and comparing it.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   start_i, seed_i   : run request (accepted in IDLE only), pattern seed
//   axi_req_o/rsp_i   : AXI manager port; all transactions use ID 0
//   busy_o, done_o    : run in progress, sticky run complete
//   err_cnt_o         : saturating error count of the run
//   first_err_addr_o  : burst address of the first error of the run
//   timeout_o         : sticky watchdog flag
// Optional macro FLOO_TGEN_TIMEOUT_EN adds a 16-bit watchdog; without it
// timeout_o is tied to 0.
// Handshake: a valid is raised only from the FSM state, stays high with a
// stable payload until valid && ready is seen on a clock edge, and never
// depends on the matching ready.
module floo_hbm_traffic_gen
  import floo_tgen_pkg::*;
#(
  parameter int unsigned          AddrWidth  = 48,
  parameter int unsigned          DataWidth  = 512,
  parameter int unsigned          IdWidth    = 3,
  parameter int unsigned          UserWidth  = 1,
  parameter int unsigned          NumTxns    = 16,
  parameter int unsigned          BurstLen   = 8,
  parameter logic [AddrWidth-1:0] AddrBase   = '0,
  parameter int unsigned          AddrStride = 4096,
  parameter type                  axi_req_t  = floo_tgen_pkg::axi_req_t,
  parameter type                  axi_rsp_t  = floo_tgen_pkg::axi_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          seed_i,
  output axi_req_t             axi_req_o,
  input  axi_rsp_t             axi_rsp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          err_cnt_o,
  output logic [AddrWidth-1:0] first_err_addr_o,
  output logic                 timeout_o
);

  localparam logic [15:0]          LastTxn  = 16'(NumTxns - 1);
  localparam logic [7:0]           AxLen    = 8'(BurstLen - 1);
  localparam logic [2:0]           AxSize   = 3'($clog2(DataWidth / 8));
  localparam logic [IdWidth-1:0]   TxnId    = '0;
  localparam logic [UserWidth-1:0] TxnUser  = '0;

  tgen_state_e            state_q, state_d;
  logic [15:0]            txn_q, txn_d;
  logic [31:0]            seed_q, seed_d;
  err_cnt_t               err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0]   first_err_addr_q, first_err_addr_d;
  logic                   done_q, done_d;

  logic [AddrWidth-1:0]   burst_addr;
  logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                   w_last, r_last_exp;
  logic [DataWidth-1:0]   w_data, r_data;
  logic                   err_event;
  logic                   wdog_fire;

  assign burst_addr = AddrBase + AddrWidth'(txn_q) * AddrWidth'(AddrStride);

  assign aw_hs = axi_req_o.aw_valid & axi_rsp_i.aw_ready;
  assign w_hs  = axi_req_o.w_valid  & axi_rsp_i.w_ready;
  assign b_hs  = axi_req_o.b_ready  & axi_rsp_i.b_valid;
  assign ar_hs = axi_req_o.ar_valid & axi_rsp_i.ar_ready;
  assign r_hs  = axi_req_o.r_ready  & axi_rsp_i.r_valid;

  assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o           = done_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_addr_q;

  // Response IDs and user bits carry nothing the generator needs.
  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user,
                        axi_rsp_i.r.id, axi_rsp_i.r.user};

  floo_tgen_pattern_gen #(
    .DataWidth (DataWidth),
    .BurstLen  (BurstLen)
  ) i_w_pattern (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state_q != ST_WR_W),
    .advance_i (w_hs),
    .seed_i    (seed_q),
    .txn_i     (txn_q),
    .last_o    (w_last),
    .data_o    (w_data)
  );

  floo_tgen_pattern_gen #(
    .DataWidth (DataWidth),
    .BurstLen  (BurstLen)
  ) i_r_pattern (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state_q != ST_RD_R),
    .advance_i (r_hs),
    .seed_i    (seed_q),
    .txn_i     (txn_q),
    .last_o    (r_last_exp),
    .data_o    (r_data)
  );

`ifdef FLOO_TGEN_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;

  assign wdog_fire = busy_o && (wdog_q == WdogLimit);
  assign timeout_o = timeout_q;

  always_comb begin
    wdog_d    = wdog_q + 16'd1;
    timeout_d = timeout_q;
    if (!busy_o || aw_hs || w_hs || b_hs || ar_hs || r_hs || wdog_fire) begin
      wdog_d = '0;
    end
    if ((state_q == ST_IDLE) && start_i) begin
      timeout_d = 1'b0;
    end
    if (wdog_fire) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign wdog_fire = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Request payloads are driven only in their own state, so every field
  // reads 0 in IDLE and after reset.
  always_comb begin
    axi_req_o = '0;
    case (state_q)
      ST_WR_AW: begin
        axi_req_o.aw_valid  = 1'b1;
        axi_req_o.aw.id     = TxnId;
        axi_req_o.aw.addr   = burst_addr;
        axi_req_o.aw.len    = AxLen;
        axi_req_o.aw.size   = AxSize;
        axi_req_o.aw.burst  = BurstIncr;
        axi_req_o.aw.user   = TxnUser;
      end
      ST_WR_W: begin
        axi_req_o.w_valid   = 1'b1;
        axi_req_o.w.data    = w_data;
        axi_req_o.w.strb    = '1;
        axi_req_o.w.last    = w_last;
        axi_req_o.w.user    = TxnUser;
      end
      ST_WR_B: axi_req_o.b_ready = 1'b1;
      ST_RD_AR: begin
        axi_req_o.ar_valid  = 1'b1;
        axi_req_o.ar.id     = TxnId;
        axi_req_o.ar.addr   = burst_addr;
        axi_req_o.ar.len    = AxLen;
        axi_req_o.ar.size   = AxSize;
        axi_req_o.ar.burst  = BurstIncr;
        axi_req_o.ar.user   = TxnUser;
      end
      ST_RD_R: axi_req_o.r_ready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    txn_d            = txn_q;
    seed_d           = seed_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    done_d           = done_q;
    err_event        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d          = ST_WR_AW;
          txn_d            = '0;
          seed_d           = seed_i;
          err_cnt_d        = '0;
          first_err_addr_d = '0;
          done_d           = 1'b0;
        end
      end
      ST_WR_AW: if (aw_hs) state_d = ST_WR_W;
      ST_WR_W:  if (w_hs && w_last) state_d = ST_WR_B;
      ST_WR_B: begin
        if (b_hs) begin
          state_d   = ST_RD_AR;
          err_event = (axi_rsp_i.b.resp != RespOkay);
        end
      end
      ST_RD_AR: if (ar_hs) state_d = ST_RD_R;
      ST_RD_R: begin
        if (r_hs) begin
          // One error per beat, however many checks fail on it.
          err_event = (axi_rsp_i.r.data != r_data) ||
                      (axi_rsp_i.r.resp != RespOkay) ||
                      (axi_rsp_i.r.last != r_last_exp);
          if (axi_rsp_i.r.last) begin
            if (txn_q == LastTxn) begin
              state_d = ST_DONE;
            end else begin
              txn_d   = txn_q + 16'd1;
              state_d = ST_WR_AW;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Watchdog expiry overrides whatever the channel logic decided.
    if (wdog_fire) begin
      state_d   = ST_DONE;
      txn_d     = txn_q;
      err_event = 1'b1;
    end

    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end

    if (err_event && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == '0) begin
        first_err_addr_d = burst_addr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      txn_q            <= '0;
      seed_q           <= '0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      txn_q            <= txn_d;
      seed_q           <= seed_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      done_q           <= done_d;
    end
  end

endmodule
